jk_ff_bank: RTL and testbench

- Parametrised, multi-bit successor to the single JK flip-flop.
- WIDTH independent flip-flops share one clock, one enable and a runtime-selectable mode: JK, D, T or SR.
- Also provides parallel load, a complementary output and a sticky flag for forbidden SR inputs.
- Used as the general-purpose state-storage element in the flip-flop library. Counters and shift structures are built on top of it.

---
 rtl/jk_ff_bank.sv | 93 +++++++++
 tb/tb_jk_ff_bank.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH flip-flops with runtime-selectable JK/D/T/SR mode, parallel load and a sticky SR-conflict flag.
// Optional activity counter is enabled by defining JK_FF_BANK_ACT_CNT_EN.
module jk_ff_bank #(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_n,
`ifdef JK_FF_BANK_ACT_CNT_EN
    output logic [CNT_W-1:0] act_cnt,
`endif
    output logic             sr_err
);

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    mode_t            cur_mode;
    logic [WIDTH-1:0] mode_next;
    logic [WIDTH-1:0] next_q;
    logic             sr_set;

    assign cur_mode = mode_t'(mode);

    // SR keeps the bit when S and R are equal, which covers both hold and the forbidden case
    always_comb begin
        mode_next = out;
        case (cur_mode)
            MODE_JK: mode_next = (j & ~out) | (~k & out);
            MODE_D:  mode_next = j;
            MODE_T:  mode_next = out ^ j;
            MODE_SR: mode_next = (j & ~k) | (out & ~(j ^ k));
            default: mode_next = out;
        endcase
    end

    always_comb begin
        next_q = out;
        if (load) begin
            next_q = load_val;
        end else if (en) begin
            next_q = mode_next;
        end
    end

    assign sr_set = en && !load && (cur_mode == MODE_SR) && (|(j & k));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out    <= RST_Q;
            sr_err <= 1'b0;
        end else begin
            out <= next_q;
            if (sr_set) begin
                sr_err <= 1'b1;
            end else if (clr_err) begin
                sr_err <= 1'b0;
            end
        end
    end

    assign out_n = ~out;

`ifdef JK_FF_BANK_ACT_CNT_EN
    // Counts edges on which any bit changes; saturates instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_cnt <= '0;
        end else if (clr_err) begin
            act_cnt <= '0;
        end else if ((next_q != out) && !(&act_cnt)) begin
            act_cnt <= act_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed scoreboard bench for jk_ff_bank (WIDTH=4, RESET_VAL=4'hA, CNT_W=2).
// Checks act_cnt too when JK_FF_BANK_ACT_CNT_EN is defined.
module tb_jk_ff_bank;

    typedef struct {
        string      tag;
        logic [3:0] exp_out;
        logic       exp_err;
        logic [1:0] exp_cnt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic       load;
    logic [3:0] load_val;
    logic       clr_err;
    logic [3:0] out;
    logic [3:0] out_n;
    logic       sr_err;
`ifdef JK_FF_BANK_ACT_CNT_EN
    logic [1:0] act_cnt;
`endif

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] prev_out = 4'h0;
    logic [1:0] model_cnt = 2'd0;

    jk_ff_bank #(.WIDTH(4), .RESET_VAL(4'hA), .CNT_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .j        (j),
        .k        (k),
        .load     (load),
        .load_val (load_val),
        .clr_err  (clr_err),
        .out      (out),
        .out_n    (out_n),
`ifdef JK_FF_BANK_ACT_CNT_EN
        .act_cnt  (act_cnt),
`endif
        .sr_err   (sr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: observed empty queue, required one entry");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (out === e.exp_out) else begin
            errors++;
            $error("[TB] FAIL %s out: observed %h expected %h", e.tag, out, e.exp_out);
        end
        checks++;
        assert (out_n === ~e.exp_out) else begin
            errors++;
            $error("[TB] FAIL %s out_n: observed %h expected %h", e.tag, out_n, ~e.exp_out);
        end
        checks++;
        assert (sr_err === e.exp_err) else begin
            errors++;
            $error("[TB] FAIL %s sr_err: observed %b expected %b", e.tag, sr_err, e.exp_err);
        end
`ifdef JK_FF_BANK_ACT_CNT_EN
        checks++;
        assert (act_cnt === e.exp_cnt) else begin
            errors++;
            $error("[TB] FAIL %s act_cnt: observed %0d expected %0d", e.tag, act_cnt, e.exp_cnt);
        end
`endif
    endtask

    // Drives one edge worth of inputs, records the expectation, then compares after the edge
    task automatic applyStimulus(input string tag, input logic r, input logic ld, input logic [3:0] lv,
                                 input logic e, input logic [1:0] m, input logic [3:0] jj,
                                 input logic [3:0] kk, input logic clr,
                                 input logic [3:0] exp_o, input logic exp_e);
        exp_t item;
        rst_n    = r;
        load     = ld;
        load_val = lv;
        en       = e;
        mode     = m;
        j        = jj;
        k        = kk;
        clr_err  = clr;
        if (!r || clr) begin
            model_cnt = 2'd0;
        end else if (exp_o != prev_out && model_cnt != 2'd3) begin
            model_cnt = model_cnt + 2'd1;
        end
        prev_out     = exp_o;
        item.tag     = tag;
        item.exp_out = exp_o;
        item.exp_err = exp_e;
        item.exp_cnt = model_cnt;
        sb.push_back(item);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; load_val = 4'h0; en = 1'b0;
        mode = 2'b00; j = 4'h0; k = 4'h0; clr_err = 1'b0;
        @(negedge clk);

        //             tag            rst  ld   lv     en   mode   j        k        clr  exp_out  exp_err
        applyStimulus("reset",        0, 1, 4'h5, 1, 2'b10, 4'hF,    4'hF,    1, 4'hA,    1'b0);
        applyStimulus("load0",        1, 1, 4'h0, 0, 2'b00, 4'h0,    4'h0,    0, 4'h0,    1'b0);
        applyStimulus("jk_mix",       1, 0, 4'h0, 1, 2'b00, 4'b1010, 4'b0110, 0, 4'b1010, 1'b0);
        applyStimulus("jk_toggle",    1, 0, 4'h0, 1, 2'b00, 4'b1111, 4'b1111, 0, 4'b0101, 1'b0);
        applyStimulus("d_mode",       1, 0, 4'h0, 1, 2'b01, 4'h3,    4'hC,    0, 4'h3,    1'b0);
        applyStimulus("t_mode",       1, 0, 4'h0, 1, 2'b10, 4'h5,    4'h0,    0, 4'h6,    1'b0);
        applyStimulus("en_low",       1, 0, 4'h0, 0, 2'b10, 4'hF,    4'h0,    0, 4'h6,    1'b0);
        applyStimulus("load_sr0",     1, 1, 4'h0, 1, 2'b11, 4'hF,    4'hF,    0, 4'h0,    1'b0);
        applyStimulus("sr_forbid",    1, 0, 4'h0, 1, 2'b11, 4'b1001, 4'b0001, 0, 4'b1000, 1'b1);
        applyStimulus("sr_set_wins",  1, 0, 4'h0, 1, 2'b11, 4'hF,    4'hF,    1, 4'b1000, 1'b1);
        applyStimulus("sr_clear",     1, 0, 4'h0, 1, 2'b11, 4'h0,    4'h0,    1, 4'b1000, 1'b0);
        applyStimulus("sr_reset_q",   1, 0, 4'h0, 1, 2'b11, 4'b0000, 4'b1000, 0, 4'b0000, 1'b0);
        applyStimulus("load_prio",    1, 1, 4'h9, 1, 2'b10, 4'hF,    4'h0,    0, 4'h9,    1'b0);
        applyStimulus("sr_err_again", 1, 0, 4'h0, 1, 2'b11, 4'h1,    4'h1,    0, 4'h9,    1'b1);
        applyStimulus("err_hold",     1, 0, 4'h0, 0, 2'b11, 4'h1,    4'h1,    0, 4'h9,    1'b1);
        applyStimulus("mid_reset",    0, 1, 4'h3, 1, 2'b10, 4'hF,    4'h0,    0, 4'hA,    1'b0);
        applyStimulus("cnt_clr",      1, 0, 4'h0, 0, 2'b00, 4'h0,    4'h0,    1, 4'hA,    1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("cnt_step%0d", i), 1, 1, (i % 2 == 0) ? 4'h1 : 4'h2,
                          0, 2'b00, 4'h0, 4'h0, 0, (i % 2 == 0) ? 4'h1 : 4'h2, 1'b0);
        end
        applyStimulus("cnt_hold",     1, 0, 4'h0, 1, 2'b00, 4'h0,    4'h0,    0, 4'h1,    1'b0);
        applyStimulus("cnt_clear",    1, 0, 4'h0, 0, 2'b00, 4'h0,    4'h0,    1, 4'h1,    1'b0);
        applyStimulus("cnt_hold2",    1, 0, 4'h0, 1, 2'b01, 4'h1,    4'h0,    0, 4'h1,    1'b0);
        applyStimulus("cnt_after",    1, 0, 4'h0, 1, 2'b10, 4'h4,    4'h0,    0, 4'h5,    1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
